clock_period_meter: RTL
=======================

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 SHALL provide parameter WIDTH, default 28, as the width of the period, high-time and internal counters.
REQ-002 SHALL provide parameter TIMEOUT, default 28'd100_000_000, as the maximum clk cycles without a rising edge before timeout; legal range 2..2^WIDTH-1.
REQ-003 SHALL provide port clk, input, 1 bit: the single system clock; all logic on posedge clk.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port sig_in, input, 1 bit: the slow or divided signal to measure, asynchronous to clk.
REQ-006 SHALL provide port period, output, WIDTH bits: clk cycles between the last two sig_in rising edges.
REQ-007 SHALL provide port high_time, output, WIDTH bits: clk cycles sig_in was high within that period.
REQ-008 SHALL provide port valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-009 SHALL provide port timeout, output, 1 bit: sticky flag indicating no rising edge within TIMEOUT cycles.
REQ-010 SHALL provide port measuring, output, 1 bit: high while the FSM is in MEASURE.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer (s1, s2), then a third register s3; rise = s2 & ~s3.
REQ-012 SHALL implement a 2-state FSM, IDLE and MEASURE; state is registered and measuring = (state == MEASURE).
REQ-013 SHALL, in IDLE with rise: go to MEASURE; cnt <= 1; hcnt <= 1; no valid pulse.
REQ-014 SHALL, in MEASURE without rise and cnt < TIMEOUT: cnt <= cnt+1; hcnt <= hcnt+1 if s2 is high, else hold.
REQ-015 SHALL, in MEASURE with rise: period <= cnt; high_time <= hcnt; valid <= 1 for exactly one cycle; timeout <= 0; cnt <= 1; hcnt <= 1; stay in MEASURE.
REQ-016 SHALL, in MEASURE without rise and cnt == TIMEOUT: go to IDLE; timeout <= 1; period <= 0; high_time <= 0; valid stays 0.
REQ-017 SHALL, when rise and cnt == TIMEOUT occur in the same cycle, give rise priority (REQ-015 applies).
REQ-018 SHALL hold period and high_time between updates, with valid at 0 in all other cycles.
REQ-019 SHALL, when sig_in is first sampled high at clk edge k, assert the valid pulse in the cycle after edge k+2 (latency 3 clk edges from sampling).
REQ-020 SHALL give a minimum measurable period of 2, with no overflow possible since cnt <= TIMEOUT < 2^WIDTH.
REQ-021 SHALL produce high_time == period when s2 is high during every cycle of the period (e.g. glitch-free constant-high is impossible; only reached via sync-aliased pulses).
REQ-022 SHALL keep timeout set in IDLE until the next valid pulse clears it.

Reset
REQ-023 SHALL, when rst = 1 at posedge clk: state <= IDLE; s1, s2, s3, cnt, hcnt, period, high_time, valid, timeout <= 0; measuring = 0.
REQ-024 SHALL, on rst asserted mid-measurement, discard the partial measurement and emit no valid pulse; the first rise after rst deasserts only arms the FSM (REQ-013).
REQ-025 SHALL give rst priority over all other events in the same cycle.

Verification
REQ-026 SHALL cover reset followed by sig_in square wave of period 8 clk, 4 high -> first valid on the second rising edge; period = 8, high_time = 4, measuring = 1.
REQ-027 SHALL cover duty variation with period 10, high 3 -> period = 10, high_time = 3 on every valid; valid pulses exactly 10 cycles apart.
REQ-028 SHALL cover the fastest input, sig_in toggling every clk cycle -> period = 2, high_time = 1.
REQ-029 SHALL cover timeout with TIMEOUT = 20 and sig_in held low after one rising edge -> timeout = 1, measuring = 0, period = 0 after cnt reaches 20; next two rising edges 6 cycles apart -> valid, period = 6, timeout = 0.
REQ-030 SHALL cover rst pulsed for 1 cycle mid-period with period 8 -> all outputs 0, no valid on the next rising edge, valid with period = 8 on the following one.
REQ-031 SHALL cover latency: sig_in rising at edge k from IDLE-armed MEASURE -> valid is high only in the cycle after edge k+2.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow asynchronous signal in clk cycles.
// One measurement per rising edge of sig_in; a missing edge for TIMEOUT cycles drops back to IDLE.
module clock_period_meter #(
  parameter int               WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_timeout;

  logic             w_rise;
  logic             w_at_limit;

  // r_s1/r_s2 resynchronise sig_in; r_s3 is only the edge-detect history.
  assign w_rise     = r_s2 & ~r_s3;
  assign w_at_limit = (r_cnt >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s1    <= sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_cnt   <= ONE;
            r_hcnt  <= ONE;
          end
        end
        ST_MEASURE: begin
          // A rise in the same cycle as the limit still completes the measurement.
          if (w_rise) begin
            r_period    <= r_cnt;
            r_high_time <= r_hcnt;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b0;
            r_cnt       <= ONE;
            r_hcnt      <= ONE;
          end else if (w_at_limit) begin
            r_state     <= ST_IDLE;
            r_timeout   <= 1'b1;
            r_period    <= '0;
            r_high_time <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
            if (r_s2) begin
              r_hcnt <= r_hcnt + ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign measuring = (r_state == ST_MEASURE);

endmodule
